mux_sel_ctrl: RTL
=================

Name: mux_sel_ctrl

Overview:
- Upstream control stage for the team's parameterized 2:1 mux. Generates its select line from a raw board pushbutton.
- Synchronizes and debounces the button, then toggles a registered select on each debounced press.
- Flags every select change with a one-cycle pulse.
- sel_o drives the mux sel_i directly: sel_o=0 picks a_i, sel_o=1 picks b_i.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive cycles the synchronized button must differ from the debounced level before that level updates; legal range ≥1
CNT_W, 16, width of the debounce and auto counters; must hold DEBOUNCE_CYCLES-1 and AUTO_PERIOD-1
AUTO_PERIOD, 8, cycles between automatic toggles; used only with AUTO_TOGGLE_EN; legal range ≥2

Ports:
clk_i  input  1  system clock, rising edge
rst_i  input  1  asynchronous, active-high reset
btn_i  input  1  raw pushbutton, asynchronous to clk_i, may bounce
hold_i  input  1  synchronous freeze; while high, no select change occurs
db_btn_o  output  1  debounced button level (registered)
sel_o  output  1  mux select (registered); 0 selects a_i, 1 selects b_i
sel_changed_o  output  1  one-cycle pulse, high in the cycle sel_o holds its new value

Behaviour:
- Reset (asynchronous, active-high) clears everything to 0: sel_o, sel_changed_o, db_btn_o, both synchronizer flops, debounce counter, auto counter. Outputs stay 0 while rst_i is high.
- Synchronizer: two flops, btn_sync = btn_i delayed 2 edges.
- Debounce:
  - When btn_sync == db_btn_o, the counter is cleared.
  - When they differ and counter < DEBOUNCE_CYCLES-1, the counter increments.
  - When they differ and counter == DEBOUNCE_CYCLES-1, db_btn_o <= btn_sync and the counter clears.
  - Any single cycle of agreement before terminal count restarts the count, so a glitch is fully rejected.
- Press detect: a request fires for one cycle when db_btn_o rises, i.e. db_btn_o=1 and its previous-cycle value=0. Release does nothing.
- State machine, two states:
  - SEL_A (sel_o=0) and SEL_B (sel_o=1).
  - Request with hold_i=0: move to the other state at the next edge; sel_changed_o=1 for exactly that cycle.
  - Request with hold_i=1: request is dropped, not queued.
  - No request: stay in the current state; sel_changed_o=0.
- Latency: count edge 1 as the first rising edge that samples the new btn_i level.
  - db_btn_o updates at edge DEBOUNCE_CYCLES+2.
  - sel_o toggles at edge DEBOUNCE_CYCLES+3.
- Back-to-back presses: each debounced rising edge toggles once. The minimum press-to-press spacing is enforced only by the debounce.
- Reset mid-operation: all progress is lost. After rst_i deasserts with btn_i already high, the full DEBOUNCE_CYCLES+3 latency applies again and produces a toggle.
- sel_o never glitches; it is driven straight from a flop.

Optional Feature:
- Macro: AUTO_TOGGLE_EN.
- Defined:
  - The auto counter increments each cycle while hold_i=0 and freezes (holds its value) while hold_i=1.
  - At count == AUTO_PERIOD-1, sel_o toggles, sel_changed_o pulses, and the counter clears.
  - A button toggle also clears the auto counter.
  - If a button request and auto terminal count coincide, exactly one toggle occurs and the counter clears.
- Undefined: no auto counter logic is present; the select changes only on button presses; AUTO_PERIOD is ignored.

Test Plan:
- Reset: rst_i=1 asynchronously mid-cycle with btn_i=1 -> sel_o, db_btn_o and sel_changed_o go to 0 immediately and remain 0 until release.
- Clean press, DEBOUNCE_CYCLES=4: btn_i 0->1 held 12 cycles, then 0 -> db_btn_o rises at edge 6; sel_o goes 0->1 at edge 7 with a single sel_changed_o pulse; the release produces no change. A second press returns sel_o to 0.
- Bounce, DEBOUNCE_CYCLES=4: btn_i high 3 cycles, low 1, high 2, low -> db_btn_o stays 0; sel_o stays 0; no pulse.
- Hold: hold_i=1 throughout a clean press -> db_btn_o rises, but sel_o and sel_changed_o stay 0. After hold_i=0, a new press toggles sel_o to 1.
- Reset mid-debounce: assert rst_i when the debounce counter =2, deassert with btn_i still high -> db_btn_o rises 6 edges after reset release; sel_o toggles at edge 7.
- AUTO_TOGGLE_EN, AUTO_PERIOD=8:
  - Idle -> sel_o toggles every 8 cycles.
  - hold_i high for 5 cycles stretches that interval to 13.
  - A press landing on the terminal count gives one toggle, and the next auto toggle follows 8 cycles later.

Source files
------------

// File: rtl/mux_sel_ctrl.sv
// Select-line controller for the 2:1 mux: synchronizes and debounces a pushbutton and toggles sel_o on each press.
// Optional build macro AUTO_TOGGLE_EN adds a periodic auto-toggle every AUTO_PERIOD unheld cycles.
module mux_sel_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16,
  parameter int AUTO_PERIOD     = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  input  logic hold_i,
  output logic db_btn_o,
  output logic sel_o,
  output logic sel_changed_o
);

  typedef enum logic {
    SEL_A = 1'b0,
    SEL_B = 1'b1
  } sel_state_e;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1) begin : g_chk_debounce
    $error("DEBOUNCE_CYCLES must be >= 1");
  end
  if (AUTO_PERIOD < 2) begin : g_chk_auto
    $error("AUTO_PERIOD must be >= 2");
  end

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic             db_btn_q, db_btn_d;
  logic             db_prev_q;
  sel_state_e       state_q, state_d;
  logic             sel_changed_q, sel_changed_d;
  logic             press_req;
  logic             btn_toggle;
  logic             do_toggle;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // A single cycle of agreement restarts the count, so glitches shorter than the window never pass.
  always_comb begin
    db_cnt_d = '0;
    db_btn_d = db_btn_q;
    if (sync2_q != db_btn_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_btn_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      db_cnt_q  <= '0;
      db_btn_q  <= 1'b0;
      db_prev_q <= 1'b0;
    end else begin
      db_cnt_q  <= db_cnt_d;
      db_btn_q  <= db_btn_d;
      db_prev_q <= db_btn_q;
    end
  end

  assign press_req  = db_btn_q & ~db_prev_q;
  assign btn_toggle = press_req & ~hold_i;

`ifdef AUTO_TOGGLE_EN
  localparam logic [CNT_W-1:0] AUTO_LAST = CNT_W'(AUTO_PERIOD - 1);

  logic [CNT_W-1:0] auto_cnt_q, auto_cnt_d;
  logic             auto_toggle;

  // Counter freezes under hold, so a terminal count reached while held fires once hold drops.
  assign auto_toggle = (auto_cnt_q == AUTO_LAST) & ~hold_i;
  assign do_toggle   = btn_toggle | auto_toggle;

  always_comb begin
    auto_cnt_d = auto_cnt_q;
    if (do_toggle) begin
      auto_cnt_d = '0;
    end else if (!hold_i) begin
      auto_cnt_d = auto_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      auto_cnt_q <= '0;
    end else begin
      auto_cnt_q <= auto_cnt_d;
    end
  end
`else
  assign do_toggle = btn_toggle;
`endif

  always_comb begin
    state_d       = state_q;
    sel_changed_d = 1'b0;
    case (state_q)
      SEL_A: begin
        if (do_toggle) begin
          state_d       = SEL_B;
          sel_changed_d = 1'b1;
        end
      end
      SEL_B: begin
        if (do_toggle) begin
          state_d       = SEL_A;
          sel_changed_d = 1'b1;
        end
      end
      default: begin
        state_d = SEL_A;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= SEL_A;
      sel_changed_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sel_changed_q <= sel_changed_d;
    end
  end

  assign db_btn_o      = db_btn_q;
  assign sel_o         = (state_q == SEL_B);
  assign sel_changed_o = sel_changed_q;

endmodule
